// File: rtl/logic_ops_pkg.sv
// logic_ops_pkg: shared definitions for the logic unit arbiter.
//   - opcode constants for the bitwise logic unit
//   - FSM state encoding (IDLE/EXEC/RESP)
//   - logic_eval(): evaluates one bit position of an operation. It returns
//     {err, result}. An illegal opcode yields {1, 0}. Callers apply it
//     across all operand bits, which keeps it independent of operand width.
package logic_ops_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_XOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic [1:0] logic_eval(input logic [2:0] op,
                                            input logic       a,
                                            input logic       b);
    case (op)
      OP_AND:  return {1'b0, a & b};
      OP_OR:   return {1'b0, a | b};
      OP_NAND: return {1'b0, ~(a & b)};
      OP_NOR:  return {1'b0, ~(a | b)};
      OP_XOR:  return {1'b0, a ^ b};
      OP_XNOR: return {1'b0, ~(a ^ b)};
      default: return 2'b10;
    endcase
  endfunction

endpackage

// File: rtl/logic_unit_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker.
// Ports:
//   i_valid       [NREQ]  request valid vector
//   i_last        [IDW]   most recently granted requester
//   o_grant_valid         at least one request is valid
//   o_grant_id    [IDW]   winner index
//   o_grant       [NREQ]  one-hot winner (all zero when no winner)
// The search starts at i_last+1 and wraps modulo NREQ. The last
// granted requester therefore has the lowest priority.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] i_valid,
  input  logic [IDW-1:0]  i_last,
  output logic            o_grant_valid,
  output logic [IDW-1:0]  o_grant_id,
  output logic [NREQ-1:0] o_grant
);

  always_comb begin
    int w_idx;
    o_grant_valid = 1'b0;
    o_grant_id    = '0;
    o_grant       = '0;
    w_idx         = 0;
    for (int k = 1; k <= NREQ; k++) begin
      w_idx = int'(i_last) + k;
      if (w_idx >= NREQ) w_idx = w_idx - NREQ;
      if (!o_grant_valid && i_valid[w_idx[IDW-1:0]]) begin
        o_grant_valid = 1'b1;
        o_grant_id    = w_idx[IDW-1:0];
      end
    end
    if (o_grant_valid) o_grant[o_grant_id] = 1'b1;
  end

endmodule

// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: NREQ requesters share one registered bitwise logic unit.
// The unit supports AND/OR/NAND/NOR/XOR/XNOR, and only one operation is in flight at a time.
// Ports:
//   clk, rst               clock; asynchronous active-high reset
//   req_valid/req_ready    per-requester request handshake (ready is one-hot or zero)
//   req_op/req_a/req_b     packed per-requester opcode (3b) and operands (WIDTH)
//   rsp_valid/rsp_ready    response handshake
//   rsp_data/rsp_id/rsp_err  result, owning requester, illegal-opcode flag
//   busy                   high whenever the FSM is not IDLE
//   op_count               completed responses, wraps modulo 2^CNTW
//   dbg_state              current FSM state encoding
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high. A request's ready is asserted only in IDLE, combinationally
// from req_valid. A response stays valid with stable payload until it is
// accepted.
module logic_unit_arbiter
  import logic_ops_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic                  busy,
  output logic [CNTW-1:0]       op_count,
  output logic [1:0]            dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic [IDW-1:0]   r_last;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IDW-1:0]   r_id;
  logic             r_rsp_valid;
  logic [WIDTH-1:0] r_rsp_data;
  logic [IDW-1:0]   r_rsp_id;
  logic             r_rsp_err;
  logic [CNTW-1:0]  r_count;

  logic             w_gv;
  logic [IDW-1:0]   w_gid;
  logic [NREQ-1:0]  w_grant;
  logic             w_take;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic [1:0]       w_bit;

  rr_pick #(
    .NREQ(NREQ),
    .IDW (IDW)
  ) u_pick (
    .i_valid      (req_valid),
    .i_last       (r_last),
    .o_grant_valid(w_gv),
    .o_grant_id   (w_gid),
    .o_grant      (w_grant)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next state and the combinational request-ready. Ready is forced low
  // while reset is asserted so no grant is advertised during reset.
  always_comb begin
    w_next    = r_state;
    w_take    = 1'b0;
    req_ready = '0;
    case (r_state)
      IDLE: begin
        if (w_gv && !rst) begin
          req_ready = w_grant;
          w_take    = 1'b1;
          w_next    = EXEC;
        end
      end
      EXEC:    w_next = RESP;
      RESP:    if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Apply the per-bit evaluator across the captured operands. The err bit is
  // the same for every position, so the last one is kept.
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    w_bit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_bit    = logic_eval(r_op, r_a[i], r_b[i]);
      w_res[i] = w_bit[0];
      w_err    = w_bit[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last      <= IDW'(NREQ - 1);
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_id        <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
      r_rsp_err   <= 1'b0;
      r_count     <= '0;
    end else begin
      if (w_take) begin
        r_op   <= req_op[3*w_gid +: 3];
        r_a    <= req_a[WIDTH*w_gid +: WIDTH];
        r_b    <= req_b[WIDTH*w_gid +: WIDTH];
        r_id   <= w_gid;
        r_last <= w_gid;
      end
      if (r_state == EXEC) begin
        r_rsp_valid <= 1'b1;
        r_rsp_data  <= w_res;
        r_rsp_err   <= w_err;
        r_rsp_id    <= r_id;
      end
      if (r_state == RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
        r_count     <= r_count + CNTW'(1);
      end
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;
  assign rsp_err   = r_rsp_err;
  assign op_count  = r_count;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
module tb_logic_unit_arbiter;
  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int CNTW  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;
  logic                  busy;
  logic [CNTW-1:0]       op_count;
  logic [1:0]            dbg_state;

  logic_unit_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW), .CNTW(CNTW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
  );

  // ---------------- clock/reset ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  function automatic logic [7:0] ref_op(input int op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      0: return a & b;
      1: return a | b;
      2: return ~(a & b);
      3: return ~(a | b);
      4: return a ^ b;
      5: return ~(a ^ b);
      default: return 8'h00;
    endcase
  endfunction

  // m_phase counts cycles since grant: 0 = waiting for a grant, 1 = computing,
  // 2 = response offered. exp_q holds {err, id, data} of the pending response.
  int          m_phase;
  int          m_last;
  int          m_count;
  logic [10:0] exp_q[$];

  always @(negedge clk) begin : cmp
    logic [3:0]  exp_ready;
    int          win;
    int          op;
    logic [7:0]  ea;
    logic [7:0]  eb;
    if (rst) begin
      m_phase = 0;
      m_last  = NREQ - 1;
      m_count = 0;
      exp_q.delete();
    end else begin
      exp_ready = '0;
      win = -1;
      if (m_phase == 0) begin
        for (int k = 1; k <= NREQ; k++) begin
          int idx;
          idx = (m_last + k) % NREQ;
          if (win < 0 && req_valid[idx]) win = idx;
        end
        if (win >= 0) exp_ready[win] = 1'b1;
      end
      check("m_req_ready", req_ready, exp_ready);
      check("m_busy", busy, m_phase != 0);
      check("m_op_count", op_count, m_count % 16);
      if (m_phase == 2) begin
        check("m_rsp_valid", rsp_valid, 1);
        if (exp_q.size() == 0) check("m_q_empty", 0, 1);
        else check("m_rsp_payload", {rsp_err, rsp_id, rsp_data}, exp_q[0]);
      end else begin
        check("m_rsp_valid", rsp_valid, 0);
      end
      // advance the model across the coming rising edge
      if (m_phase == 0 && win >= 0) begin
        op = int'(req_op[3*win +: 3]);
        ea = req_a[8*win +: 8];
        eb = req_b[8*win +: 8];
        exp_q.push_back({(op > 5) ? 1'b1 : 1'b0, 2'(win), ref_op(op, ea, eb)});
        m_last  = win;
        m_phase = 1;
      end else if (m_phase == 1) begin
        m_phase = 2;
      end else if (m_phase == 2 && rsp_ready) begin
        void'(exp_q.pop_front());
        m_count++;
        m_phase = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_valid[i]      = 1'b1;
    req_op[3*i +: 3]  = op;
    req_a[8*i +: 8]   = a;
    req_b[8*i +: 8]   = b;
  endtask

  task automatic apply_reset();
    #1 rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grant(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!req_ready[i] && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("grant_wait", req_ready[i], 1);
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("rsp_wait", rsp_valid, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("idle_wait", busy, 0);
    tick();
  endtask

  // Called just after a rising edge with rsp_ready high; returns the response
  // and leaves the unit back in IDLE.
  task automatic do_op(input int i, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] d, output logic e, output logic [1:0] id);
    set_req(i, op, a, b);
    wait_grant(i);
    tick();
    req_valid[i] = 1'b0;
    wait_rsp();
    d  = rsp_data;
    e  = rsp_err;
    id = rsp_id;
    tick();
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    logic [7:0] d;
    logic       e;
    logic [1:0] id;
    int         order[8];
    int         exp_order[8];
    int         got;
    int         n;

    rst = 1'b0;
    req_valid = '0;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    rsp_ready = 1'b1;
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};

    // reset values take effect immediately
    #2 rst = 1'b1;
    #1;
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_rsp_id", rsp_id, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_busy", busy, 0);
    check("rst_op_count", op_count, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // single request: requester 2, XOR F0^3C = CC, rsp_valid two cycles after grant
    set_req(2, 3'd4, 8'hF0, 8'h3C);
    @(negedge clk);
    check("single_ready", req_ready, 4'b0100);
    tick();
    req_valid[2] = 1'b0;
    @(negedge clk);
    check("single_n1_valid", rsp_valid, 0);
    check("single_n1_ready", req_ready, 0);
    @(negedge clk);
    check("single_n2_valid", rsp_valid, 1);
    check("single_data", rsp_data, 8'hCC);
    check("single_id", rsp_id, 2);
    check("single_err", rsp_err, 0);
    tick();
    check("single_count", op_count, 1);

    // illegal opcode, then XNOR on the same operands
    do_op(1, 3'd7, 8'hAA, 8'h55, d, e, id);
    check("illegal_data", d, 8'h00);
    check("illegal_err", e, 1);
    check("illegal_id", id, 1);
    do_op(1, 3'd5, 8'hAA, 8'h55, d, e, id);
    check("xnor_data", d, 8'h00);
    check("xnor_err", e, 0);
    do_op(3, 3'd1, 8'h0F, 8'h30, d, e, id);
    check("or_data", d, 8'h3F);
    do_op(0, 3'd3, 8'h0F, 8'h30, d, e, id);
    check("nor_data", d, 8'hC0);
    do_op(2, 3'd0, 8'hC3, 8'h0F, d, e, id);
    check("and_data", d, 8'h03);
    check("count_before_reset", op_count, 6);

    // reset while a response is held under backpressure
    rsp_ready = 1'b0;
    set_req(3, 3'd0, 8'hFF, 8'hFF);
    wait_rsp();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_op_count", op_count, 0);
    check("midrst_busy", busy, 0);
    for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 8'h5A + 8'(i), 8'h33);
    rsp_ready = 1'b1;
    tick();
    rst = 1'b0;

    // round robin with all four requesting
    got = 0;
    n = 0;
    while (got < 8 && n < 60) begin
      @(negedge clk);
      if (req_ready != 0) begin
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) order[got] = i;
        got++;
      end
      n++;
    end
    check("rr_grants", got, 8);
    tick();
    req_valid = '0;
    wait_idle();
    for (int i = 0; i < 8; i++) check("rr_order", order[i], exp_order[i]);
    check("rr_count", op_count, 8);

    // backpressure: NAND FF,0F = F0 held for 5 cycles
    rsp_ready = 1'b0;
    set_req(0, 3'd2, 8'hFF, 8'h0F);
    wait_grant(0);
    tick();
    req_valid[0] = 1'b0;
    set_req(1, 3'd4, 8'h12, 8'h34);
    set_req(2, 3'd1, 8'h40, 8'h02);
    wait_rsp();
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", rsp_valid, 1);
      check("bp_data", rsp_data, 8'hF0);
      check("bp_ready", req_ready, 0);
      @(negedge clk);
    end
    tick();
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    check("bp_next_grant", req_ready, 4'b0010);
    tick();
    req_valid = '0;
    wait_idle();
    check("bp_count", op_count, 10);

    // counter wrap with a 4-bit counter
    apply_reset();
    check("wrap_reset_count", op_count, 0);
    for (int k = 0; k < 17; k++) begin
      do_op(k % 4, 3'(k % 8), 8'(8'h11 * k), ~8'(8'h07 * k), d, e, id);
      if (k == 15) check("wrap_zero", op_count, 0);
    end
    check("wrap_count", op_count, 1);

    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
